flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares the single toggle-handshake flash read port (23-bit word-aligned address, 16-bit data) between two requesters.
- Client A is the ROM loader; client B is a secondary reader, e.g. save/OSD data.
- Sits between the requesters and the flash controller. Serialises one read at a time, captures the returned word per client, and guards against a hung controller with a timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: WAIT-state cycle limit before a read is aborted. 0 disables the timeout.
- TO_DATA, 16'hFFFF: data word returned to the client on timeout.

Ports:
- iclk  in  1  system clock
- ireset_n  in  1  reset, asynchronous, active-low
- ia_addr  in  23  client A word-aligned flash address
- ia_req  in  1  client A request toggle
- oa_ack  out  1  client A ack toggle
- oa_data  out  16  client A read data
- ib_addr  in  23  client B address
- ib_req  in  1  client B request toggle
- ob_ack  out  1  client B ack toggle
- ob_data  out  16  client B read data
- ofl_addr  out  23  flash controller address
- ofl_req  out  1  flash controller request toggle
- ifl_ack  in  1  flash controller ack toggle
- ifl_data  in  16  flash controller read data
- ogrant  out  1  owner of current/last transfer (0=A, 1=B)
- obusy  out  1  high in every state except IDLE
- otimeout  out  1  sticky: a timeout has occurred since reset

Behaviour:
- Reset values (async on ireset_n low, any state): every output is 0, including ofl_addr, both data words and the timer. State is IDLE. In-flight transfers are dropped and no ack toggle is issued.
- Client pending condition: x_req != x_ack. A client toggles req once and then waits for ack to equal req. The address must be stable from the toggle until ack. Toggling again while pending is a protocol violation; behaviour is unspecified.
- States:
  - IDLE: on pending request(s), pick the winner, set ogrant, latch the winner's address into ofl_addr, and go to ISSUE.
  - ISSUE: ofl_req <= ~ifl_ack (always re-synchronises to the controller), clear the timer, go to WAIT.
  - WAIT: when ofl_req == ifl_ack, capture ifl_data into the winner's data register and go to DONE. Otherwise increment the timer. If TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1, load TO_DATA into the winner's data register, set otimeout, and go to DONE.
  - DONE: toggle the winner's ack, go to IDLE.
- Arbitration in IDLE: fixed priority, A over B. With both pending, A is served first and B on the next IDLE visit.
- Latency:
  - Pending seen at edge E1 (IDLE) -> ofl_req toggles at E2.
  - Controller ack at edge Ek -> data captured at Ek+1 -> client ack toggles at Ek+2.
  - Minimum turnaround is 4 cycles plus the controller time.
- Data: each client's data register changes only at its own capture/timeout. It is stable at and after the ack toggle until that client's next completion.
- Timer: width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- A late controller ack after a timeout is ignored. The next ISSUE re-aligns ofl_req.
- ofl_addr holds its last value while IDLE.

Optional Feature:
- Macro FLASH_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-served register, reset 0 (A), records each winner. When both clients are pending, the client not last served wins.
- Undefined: fixed priority A over B, as above.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Single A read: ia_addr=23'h000100, toggle ia_req; controller acks after 5 cycles with 16'hBEEF -> ofl_addr=23'h000100, ofl_req toggles once, oa_data=16'hBEEF, oa_ack toggles 2 cycles after ifl_ack; ob_ack unchanged.
- Simultaneous A and B toggles in the same cycle, addresses 23'h10 / 23'h20 -> A served first, then B; ofl_addr sequence 23'h10, 23'h20. With FLASH_ARB_RR_EN, a second simultaneous pair after B was last served -> A first.
- Back-to-back A streaming of 64 sequential words while B is held pending -> fixed priority serves B only when A is not pending in IDLE. With RR, service alternates A/B.
- Timeout: TIMEOUT_CYCLES=16, controller never acks -> after 16 WAIT cycles oa_data=16'hFFFF, oa_ack toggles, otimeout=1 and stays 1. The next request issues normally with ofl_req = ~ifl_ack.
- Reset mid-WAIT: assert ireset_n=0 asynchronously -> all outputs 0 immediately without waiting for a clock edge; no ack toggle. After release with no pending request, obusy=0.
- TIMEOUT_CYCLES=0 with a 5000-cycle controller stall -> no timeout, correct data delivered, otimeout=0.

Source files
------------

// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
//
// Shares one toggle-handshake flash read port between two requesters:
//   client A - ROM loader
//   client B - secondary reader (save / OSD data)
// One read is in flight at a time. The returned word is captured into a data
// register owned by the winning client. A WAIT-state timer aborts reads that
// the controller never answers, returning TO_DATA instead.
//
// Build option:
//   FLASH_ARB_RR_EN  defined   -> round-robin between A and B when both pending
//                    undefined -> fixed priority, A over B
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT-state cycle limit before a read is aborted (0 = never)
//   TO_DATA         word handed to the client when a read times out
//
// Ports:
//   iclk, ireset_n        clock, asynchronous active-low reset
//   ia_addr/ia_req        client A address / request toggle
//   oa_ack/oa_data        client A ack toggle / read data
//   ib_addr/ib_req        client B address / request toggle
//   ob_ack/ob_data        client B ack toggle / read data
//   ofl_addr/ofl_req      flash controller address / request toggle
//   ifl_ack/ifl_data      flash controller ack toggle / read data
//   ogrant                owner of the current/last transfer (0=A, 1=B)
//   obusy                 high whenever the FSM is not IDLE
//   otimeout              sticky: a timeout has occurred since reset
// -----------------------------------------------------------------------------
module flash_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] TO_DATA        = 16'hFFFF
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic [22:0] ia_addr,
  input  logic        ia_req,
  output logic        oa_ack,
  output logic [15:0] oa_data,
  input  logic [22:0] ib_addr,
  input  logic        ib_req,
  output logic        ob_ack,
  output logic [15:0] ob_data,
  output logic [22:0] ofl_addr,
  output logic        ofl_req,
  input  logic        ifl_ack,
  input  logic [15:0] ifl_data,
  output logic        ogrant,
  output logic        obusy,
  output logic        otimeout
);

  // Timer must be able to hold TIMEOUT_CYCLES; keep at least one bit when the
  // timeout is disabled so the register stays legal.
  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] TO_LAST   = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_reg,   state_next;
  logic          grant_reg,   grant_next;
  logic [22:0]   fl_addr_reg, fl_addr_next;
  logic          fl_req_reg,  fl_req_next;
  logic          a_ack_reg,   a_ack_next;
  logic          b_ack_reg,   b_ack_next;
  logic [15:0]   a_data_reg,  a_data_next;
  logic [15:0]   b_data_reg,  b_data_next;
  logic [TW-1:0] timer_reg,   timer_next;
  logic          timeout_reg, timeout_next;

  logic a_pend;
  logic b_pend;
  logic pick_b;

  // A client is pending while its request toggle differs from its ack toggle.
  assign a_pend = (ia_req != a_ack_reg);
  assign b_pend = (ib_req != b_ack_reg);

`ifdef FLASH_ARB_RR_EN
  // Remembers the last winner so that a double request goes to the other one.
  logic last_reg, last_next;

  assign pick_b = b_pend && (!a_pend || !last_reg);
`else
  assign pick_b = b_pend && !a_pend;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    fl_addr_next = fl_addr_reg;
    fl_req_next  = fl_req_reg;
    a_ack_next   = a_ack_reg;
    b_ack_next   = b_ack_reg;
    a_data_next  = a_data_reg;
    b_data_next  = b_data_reg;
    timer_next   = timer_reg;
    timeout_next = timeout_reg;
`ifdef FLASH_ARB_RR_EN
    last_next    = last_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (a_pend || b_pend) begin
          grant_next   = pick_b;
          fl_addr_next = pick_b ? ib_addr : ia_addr;
`ifdef FLASH_ARB_RR_EN
          last_next    = pick_b;
`endif
          state_next   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Derive the new toggle from the controller's ack rather than flipping
        // our own copy: a read aborted by timeout leaves the two out of step.
        fl_req_next = ~ifl_ack;
        timer_next  = '0;
        state_next  = ST_WAIT;
      end

      ST_WAIT: begin
        if (fl_req_reg == ifl_ack) begin
          if (grant_reg) b_data_next = ifl_data;
          else           a_data_next = ifl_data;
          state_next = ST_DONE;
        end else begin
          if (timer_reg != TIMER_MAX) timer_next = timer_reg + TW'(1);
          if ((TIMEOUT_CYCLES != 0) && (timer_reg == TO_LAST)) begin
            if (grant_reg) b_data_next = TO_DATA;
            else           a_data_next = TO_DATA;
            timeout_next = 1'b1;
            state_next   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (grant_reg) b_ack_next = ~b_ack_reg;
        else           a_ack_next = ~a_ack_reg;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= 1'b0;
      fl_addr_reg <= '0;
      fl_req_reg  <= 1'b0;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_data_reg  <= '0;
      b_data_reg  <= '0;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
`ifdef FLASH_ARB_RR_EN
      last_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      fl_addr_reg <= fl_addr_next;
      fl_req_reg  <= fl_req_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      a_data_reg  <= a_data_next;
      b_data_reg  <= b_data_next;
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
`ifdef FLASH_ARB_RR_EN
      last_reg    <= last_next;
`endif
    end
  end

  assign oa_ack   = a_ack_reg;
  assign oa_data  = a_data_reg;
  assign ob_ack   = b_ack_reg;
  assign ob_data  = b_data_reg;
  assign ofl_addr = fl_addr_reg;
  assign ofl_req  = fl_req_reg;
  assign ogrant   = grant_reg;
  assign obusy    = (state_reg != ST_IDLE);
  assign otimeout = timeout_reg;

endmodule

// File: tb/tb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_arbiter
//
// Directed bench for flash_arbiter. A behavioural flash controller answers
// each request with a word derived from the address. Expected client data and
// the expected order of flash addresses are queued when stimulus is driven and
// popped by monitors when the DUT acks a client or starts a flash read.
// A second instance with TIMEOUT_CYCLES=0 is driven by hand for a long stall.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flash_arbiter;

  localparam logic [15:0] TO_DATA = 16'hFFFF;

  typedef struct {
    logic [15:0] data;
    bit          to;
  } exp_t;

  logic        iclk;
  logic        ireset_n;
  logic [22:0] ia_addr, ib_addr, ofl_addr;
  logic        ia_req, oa_ack, ib_req, ob_ack;
  logic        ofl_req, ifl_ack, ogrant, obusy, otimeout;
  logic [15:0] oa_data, ob_data, ifl_data;

  logic [22:0] a0_addr, fl0_addr;
  logic        a0_req, a0_ack, b0_ack, fl0_req, fl0_ack, grant0, busy0, timeout0;
  logic [15:0] a0_data, b0_data, fl0_data;

  int vectors   = 0;
  int errs      = 0;
  int cyc       = 0;
  int flack_cyc = 0;
  int busy_cyc  = 0;
  bit hang      = 1'b0;
  int ctl_delay = 5;

  exp_t        exp_a_q[$];
  exp_t        exp_b_q[$];
  logic [22:0] exp_fl_q[$];

  flash_arbiter #(.TIMEOUT_CYCLES(16), .TO_DATA(TO_DATA)) dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .ia_addr(ia_addr), .ia_req(ia_req), .oa_ack(oa_ack), .oa_data(oa_data),
    .ib_addr(ib_addr), .ib_req(ib_req), .ob_ack(ob_ack), .ob_data(ob_data),
    .ofl_addr(ofl_addr), .ofl_req(ofl_req), .ifl_ack(ifl_ack), .ifl_data(ifl_data),
    .ogrant(ogrant), .obusy(obusy), .otimeout(otimeout)
  );

  flash_arbiter #(.TIMEOUT_CYCLES(0), .TO_DATA(TO_DATA)) dut0 (
    .iclk(iclk), .ireset_n(ireset_n),
    .ia_addr(a0_addr), .ia_req(a0_req), .oa_ack(a0_ack), .oa_data(a0_data),
    .ib_addr(23'h0), .ib_req(1'b0), .ob_ack(b0_ack), .ob_data(b0_data),
    .ofl_addr(fl0_addr), .ofl_req(fl0_req), .ifl_ack(fl0_ack), .ifl_data(fl0_data),
    .ogrant(grant0), .obusy(busy0), .otimeout(timeout0)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  always @(posedge iclk) cyc <= cyc + 1;

  function automatic logic [15:0] fdata(input logic [22:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_oa_ack"},   {31'b0, oa_ack},   32'h0);
    check({p, "_ob_ack"},   {31'b0, ob_ack},   32'h0);
    check({p, "_oa_data"},  {16'b0, oa_data},  32'h0);
    check({p, "_ob_data"},  {16'b0, ob_data},  32'h0);
    check({p, "_ofl_addr"}, {9'b0, ofl_addr},  32'h0);
    check({p, "_ofl_req"},  {31'b0, ofl_req},  32'h0);
    check({p, "_ogrant"},   {31'b0, ogrant},   32'h0);
    check({p, "_obusy"},    {31'b0, obusy},    32'h0);
    check({p, "_otimeout"}, {31'b0, otimeout}, 32'h0);
  endtask

  // Flash controller model: answers after ctl_delay cycles unless hung.
  initial begin
    int cnt;
    cnt = 0;
    ifl_ack = 1'b0;
    ifl_data = 16'h0;
    forever begin
      @(posedge iclk); #1;
      if (ofl_req !== ifl_ack && !hang) begin
        if (cnt >= ctl_delay) begin
          ifl_data = fdata(ofl_addr);
          ifl_ack  = ofl_req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Flash-side monitor: address order at each new read, toggle re-sync after ISSUE.
  initial begin
    logic pb, pk, chk, exp_req;
    pb = 1'b0; pk = 1'b0; chk = 1'b0;
    forever begin
      @(negedge iclk);
      if (!ireset_n) begin
        pb = 1'b0; chk = 1'b0; pk = ifl_ack;
      end else begin
        if (chk) begin
          exp_req = ~ifl_ack;
          check("fl_req_sync", {31'b0, ofl_req}, {31'b0, exp_req});
          chk = 1'b0;
        end
        if (obusy && !pb) begin
          busy_cyc = cyc;
          chk = 1'b1;
          if (exp_fl_q.size() == 0) check("fl_unexpected_issue", {31'b0, obusy}, 32'h0);
          else check("fl_addr", {9'b0, ofl_addr}, {9'b0, exp_fl_q.pop_front()});
        end
        pb = obusy;
        if (ifl_ack !== pk) begin
          flack_cyc = cyc;
          pk = ifl_ack;
        end
      end
    end
  end

  // Client A ack monitor
  initial begin
    logic p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge iclk);
      if (!ireset_n) p = 1'b0;
      else if (oa_ack !== p) begin
        if (exp_a_q.size() == 0) check("A_unexpected_ack", {31'b0, oa_ack}, {31'b0, p});
        else begin
          e = exp_a_q.pop_front();
          check("A_data", {16'b0, oa_data}, {16'b0, e.data});
          if (e.to) check("A_to_latency", cyc - busy_cyc, 32'd18);
          else      check("A_ack_latency", cyc - flack_cyc, 32'd2);
          $display("A ack: data=%h", oa_data);
        end
        p = oa_ack;
      end
    end
  end

  // Client B ack monitor
  initial begin
    logic p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge iclk);
      if (!ireset_n) p = 1'b0;
      else if (ob_ack !== p) begin
        if (exp_b_q.size() == 0) check("B_unexpected_ack", {31'b0, ob_ack}, {31'b0, p});
        else begin
          e = exp_b_q.pop_front();
          check("B_data", {16'b0, ob_data}, {16'b0, e.data});
          if (e.to) check("B_to_latency", cyc - busy_cyc, 32'd18);
          else      check("B_ack_latency", cyc - flack_cyc, 32'd2);
          $display("B ack: data=%h", ob_data);
        end
        p = ob_ack;
      end
    end
  end

  task automatic req_a(input logic [22:0] a, input bit to);
    exp_t e;
    e.data = to ? TO_DATA : fdata(a);
    e.to   = to;
    exp_a_q.push_back(e);
    ia_addr = a;
    ia_req  = ~ia_req;
  endtask

  task automatic req_b(input logic [22:0] a, input bit to);
    exp_t e;
    e.data = to ? TO_DATA : fdata(a);
    e.to   = to;
    exp_b_q.push_back(e);
    ib_addr = a;
    ib_req  = ~ib_req;
  endtask

  task automatic wait_a(input int lim);
    int n;
    n = 0;
    while (oa_ack !== ia_req && n < lim) begin
      @(posedge iclk); #1;
      n++;
    end
    check("A_done", {31'b0, oa_ack}, {31'b0, ia_req});
  endtask

  task automatic wait_b(input int lim);
    int n;
    n = 0;
    while (ob_ack !== ib_req && n < lim) begin
      @(posedge iclk); #1;
      n++;
    end
    check("B_done", {31'b0, ob_ack}, {31'b0, ib_req});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // Directed sequence
  initial begin
    int n;
    logic exp_req;
    ireset_n = 1'b0;
    ia_req = 1'b0; ib_req = 1'b0; ia_addr = '0; ib_addr = '0;
    a0_req = 1'b0; a0_addr = '0; fl0_ack = 1'b0; fl0_data = '0;

    // Reset values
    #2;
    check_zero("RST0");
    repeat (3) @(negedge iclk);
    ireset_n = 1'b1;
    step(1);

    // Single A read
    exp_fl_q.push_back(23'h000100);
    req_a(23'h000100, 1'b0);
    wait_a(100);
    check("T1_ob_ack", {31'b0, ob_ack}, {31'b0, ib_req});
    check("T1_grant", {31'b0, ogrant}, 32'h0);

    // Simultaneous pair (A last served so far)
`ifdef FLASH_ARB_RR_EN
    exp_fl_q.push_back(23'h20); exp_fl_q.push_back(23'h10);
`else
    exp_fl_q.push_back(23'h10); exp_fl_q.push_back(23'h20);
`endif
    req_a(23'h10, 1'b0);
    req_b(23'h20, 1'b0);
    wait_a(100);
    wait_b(100);

    // Single B read, leaves B as last served
    exp_fl_q.push_back(23'h30);
    req_b(23'h30, 1'b0);
    wait_b(100);
    check("T3_grant", {31'b0, ogrant}, 32'h1);

    // Second simultaneous pair: A first in both builds
    exp_fl_q.push_back(23'h40); exp_fl_q.push_back(23'h50);
    req_a(23'h40, 1'b0);
    req_b(23'h50, 1'b0);
    wait_a(100);
    wait_b(100);

    // A streams 64 words while B holds one request pending
`ifdef FLASH_ARB_RR_EN
    exp_fl_q.push_back(23'h1000);
    exp_fl_q.push_back(23'h60);
    for (int i = 1; i < 64; i++) exp_fl_q.push_back(23'h1000 + 23'(i));
`else
    for (int i = 0; i < 64; i++) exp_fl_q.push_back(23'h1000 + 23'(i));
    exp_fl_q.push_back(23'h60);
`endif
    req_b(23'h60, 1'b0);
    for (int i = 0; i < 64; i++) begin
      req_a(23'h1000 + 23'(i), 1'b0);
      wait_a(100);
    end
    wait_b(100);
    check("T4_fl_q_empty", exp_fl_q.size(), 32'h0);

    // Timeout with a hung controller
    hang = 1'b1;
    exp_fl_q.push_back(23'h300);
    req_a(23'h300, 1'b1);
    wait_a(100);
    check("T5_timeout", {31'b0, otimeout}, 32'h1);

    // Next read issued while still hung: ofl_req must re-align to ~ifl_ack
    exp_fl_q.push_back(23'h310);
    req_a(23'h310, 1'b0);
    step(4);
    hang = 1'b0;
    wait_a(100);
    check("T6_timeout_sticky", {31'b0, otimeout}, 32'h1);

    // Asynchronous reset in the middle of WAIT
    hang = 1'b1;
    exp_fl_q.push_back(23'h400);
    req_a(23'h400, 1'b0);
    step(6);
    #2;
    ireset_n = 1'b0;
    #1;
    check_zero("RSTW");
    exp_a_q.delete();
    ia_req = 1'b0;
    ib_req = 1'b0;
    hang = 1'b0;
    repeat (2) @(negedge iclk);
    #2;
    ireset_n = 1'b1;
    step(3);
    check("T7_busy_after_rst", {31'b0, obusy}, 32'h0);
    check("T7_oa_ack_after_rst", {31'b0, oa_ack}, 32'h0);

    // Normal read after reset
    exp_fl_q.push_back(23'h500);
    req_a(23'h500, 1'b0);
    wait_a(100);
    check("T7_timeout_cleared", {31'b0, otimeout}, 32'h0);

    // TIMEOUT_CYCLES=0 instance with a 5000-cycle stall
    a0_addr = 23'h555;
    a0_req  = 1'b1;
    n = 0;
    while (fl0_req === fl0_ack && n < 20) begin
      step(1);
      n++;
    end
    exp_req = ~fl0_ack;
    check("S_issue", {31'b0, fl0_req}, {31'b0, exp_req});
    check("S_addr", {9'b0, fl0_addr}, 32'h555);
    step(5000);
    check("S_no_ack_during_stall", {31'b0, a0_ack}, 32'h0);
    check("S_no_timeout_during_stall", {31'b0, timeout0}, 32'h0);
    fl0_data = 16'h1234;
    fl0_ack  = fl0_req;
    n = 0;
    while (a0_ack !== a0_req && n < 10) begin
      step(1);
      n++;
    end
    check("S_ack", {31'b0, a0_ack}, {31'b0, a0_req});
    check("S_data", {16'b0, a0_data}, 32'h1234);
    check("S_timeout", {31'b0, timeout0}, 32'h0);
    $display("S ack: data=%h", a0_data);

    step(5);
    check("END_a_q_empty", exp_a_q.size(), 32'h0);
    check("END_b_q_empty", exp_b_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
